// File: rtl/ex_stage_nway.sv
// N-lane execute stage: latches an issue bundle, computes per-lane ALU results,
// resolves branches oldest-lane-first, and runs MULs on one shared shift-add unit.
module ex_stage_nway #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  output logic                    in_ready,
  input  logic [32*LANES-1:0]     pc,
  input  logic [DATA_W*LANES-1:0] rs_val,
  input  logic [DATA_W*LANES-1:0] rt_val,
  input  logic [DATA_W*LANES-1:0] byp_a,
  input  logic [DATA_W*LANES-1:0] byp_b,
  input  logic [IMM_W*LANES-1:0]  imm,
  input  logic [LANES-1:0]        exsign,
  input  logic [2*LANES-1:0]      srca_sel,
  input  logic [2*LANES-1:0]      srcb_sel,
  input  logic [4*LANES-1:0]      alu_op,
  input  logic [2*LANES-1:0]      pcsrc,
  output logic [LANES-1:0]        out_valid,
  input  logic                    out_ready,
  output logic [DATA_W*LANES-1:0] alu_out,
  output logic                    set_pc,
  output logic [31:0]             ex_pc
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {S_EMPTY, S_MUL, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] v, input logic sgn);
    ext_imm = sgn ? {{(DATA_W-IMM_W){v[IMM_W-1]}}, v} : {{(DATA_W-IMM_W){1'b0}}, v};
  endfunction

  function automatic logic [31:0] ext_imm32(input logic [IMM_W-1:0] v, input logic sgn);
    ext_imm32 = sgn ? {{(32-IMM_W){v[IMM_W-1]}}, v} : {{(32-IMM_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] pick_a(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] rs,
                                               input logic [DATA_W-1:0] byp);
    case (sel)
      2'b01:   pick_a = rs;
      2'b11:   pick_a = byp;
      default: pick_a = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pick_b(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] rt,
                                               input logic [DATA_W-1:0] ext,
                                               input logic [DATA_W-1:0] byp);
    case (sel)
      2'b01:   pick_b = rt;
      2'b10:   pick_b = ext;
      2'b11:   pick_b = byp;
      default: pick_b = '0;
    endcase
  endfunction

  function automatic logic [LW-1:0] lowest(input logic [LANES-1:0] m);
    lowest = '0;
    for (int i = LANES-1; i >= 0; i--)
      if (m[i]) lowest = LW'(i);
  endfunction

  state_t state, state_nx;

  logic [LANES-1:0]        h_valid, h_exsign;
  logic [32*LANES-1:0]     h_pc;
  logic [DATA_W*LANES-1:0] h_rs, h_rt, h_ba, h_bb;
  logic [IMM_W*LANES-1:0]  h_imm;
  logic [2*LANES-1:0]      h_asel, h_bsel, h_pcsrc;
  logic [4*LANES-1:0]      h_op;
  logic                    pc_sent;

  logic [LANES-1:0]  mul_pend;
  logic [LW-1:0]     mul_lane;
  logic [CW-1:0]     mul_cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_nx;
  logic [DATA_W-1:0] mul_res [LANES];

  logic [DATA_W-1:0] in_a [LANES];
  logic [DATA_W-1:0] in_b [LANES];
  logic [DATA_W-1:0] op_a [LANES];
  logic [DATA_W-1:0] op_b [LANES];
  logic [DATA_W-1:0] res  [LANES];
  logic [LANES-1:0]  in_mul, zf, taken, squash;
  logic              accept, mul_last, br_found;
  logic [31:0]       br_target;

  // Operands for incoming lanes (to seed the first multiply) and for held lanes.
  always_comb begin
    in_mul = '0;
    for (int i = 0; i < LANES; i++) begin
      in_a[i] = pick_a(srca_sel[2*i +: 2], rs_val[i*DATA_W +: DATA_W], byp_a[i*DATA_W +: DATA_W]);
      in_b[i] = pick_b(srcb_sel[2*i +: 2], rt_val[i*DATA_W +: DATA_W],
                       ext_imm(imm[i*IMM_W +: IMM_W], exsign[i]), byp_b[i*DATA_W +: DATA_W]);
      in_mul[i] = in_valid[i] && (alu_op[4*i +: 4] == OP_MUL);
      op_a[i] = pick_a(h_asel[2*i +: 2], h_rs[i*DATA_W +: DATA_W], h_ba[i*DATA_W +: DATA_W]);
      op_b[i] = pick_b(h_bsel[2*i +: 2], h_rt[i*DATA_W +: DATA_W],
                       ext_imm(h_imm[i*IMM_W +: IMM_W], h_exsign[i]), h_bb[i*DATA_W +: DATA_W]);
    end
  end

  // Per-lane ALU plus branch resolution; the first taken lane squashes all later lanes.
  always_comb begin
    br_found  = 1'b0;
    br_target = 32'h0;
    taken     = '0;
    squash    = '0;
    zf        = '0;
    for (int i = 0; i < LANES; i++) begin
      res[i] = '0;
      case (h_op[4*i +: 4])
        OP_ADD:  res[i] = op_a[i] + op_b[i];
        OP_SUB:  res[i] = op_a[i] - op_b[i];
        OP_AND:  res[i] = op_a[i] & op_b[i];
        OP_OR:   res[i] = op_a[i] | op_b[i];
        OP_XOR:  res[i] = op_a[i] ^ op_b[i];
        OP_SLT:  res[i] = {{(DATA_W-1){1'b0}}, $signed(op_a[i]) < $signed(op_b[i])};
        OP_SLTU: res[i] = {{(DATA_W-1){1'b0}}, op_a[i] < op_b[i]};
        OP_SLL:  res[i] = op_b[i] << op_a[i][4:0];
        OP_SRL:  res[i] = op_b[i] >> op_a[i][4:0];
        OP_LUI:  res[i] = {h_imm[i*IMM_W +: IMM_W], {(DATA_W-IMM_W){1'b0}}};
        OP_MUL:  res[i] = mul_res[i];
        default: res[i] = '0;
      endcase
      zf[i] = (op_a[i] == op_b[i]);
      case (h_pcsrc[2*i +: 2])
        2'b01:   taken[i] = h_valid[i] && zf[i];
        2'b10:   taken[i] = h_valid[i];
        2'b11:   taken[i] = h_valid[i] && !zf[i];
        default: taken[i] = 1'b0;
      endcase
      squash[i] = br_found;
      if (!br_found && taken[i]) begin
        br_found = 1'b1;
        if (h_pcsrc[2*i +: 2] == 2'b10)
          br_target = {h_pc[i*32+28 +: 4], {(26-IMM_W){1'b0}}, h_imm[i*IMM_W +: IMM_W], 2'b00};
        else
          br_target = h_pc[i*32 +: 32] + (ext_imm32(h_imm[i*IMM_W +: IMM_W], h_exsign[i]) << 2);
      end
    end
  end

  // Handshake and next-state logic; flush overrides everything.
  always_comb begin
    state_nx = state;
    mul_last = (mul_cnt == CW'(DATA_W-1));
    in_ready = !flush && ((state == S_EMPTY) || ((state == S_DONE) && out_ready));
    accept   = in_ready && (|in_valid);
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_nx = (|in_mul) ? S_MUL : S_DONE;
        S_MUL:   if (mul_last && (mul_pend == '0)) state_nx = S_DONE;
        S_DONE:  if (out_ready) state_nx = accept ? ((|in_mul) ? S_MUL : S_DONE) : S_EMPTY;
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    acc_nx    = acc + (mplier[0] ? mcand : '0);
    out_valid = (state == S_DONE) ? (h_valid & ~squash) : '0;
    for (int i = 0; i < LANES; i++)
      alu_out[i*DATA_W +: DATA_W] = (state == S_DONE) ? res[i] : '0;
    set_pc = (state == S_DONE) && br_found && !pc_sent && !flush;
    ex_pc  = set_pc ? br_target : 32'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_EMPTY;
    else        state <= state_nx;
  end

  // Bundle capture and the shift-add multiplier; pending MUL lanes retire lowest-first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_valid  <= '0;
      h_exsign <= '0;
      h_pc     <= '0;
      h_rs     <= '0;
      h_rt     <= '0;
      h_ba     <= '0;
      h_bb     <= '0;
      h_imm    <= '0;
      h_asel   <= '0;
      h_bsel   <= '0;
      h_pcsrc  <= '0;
      h_op     <= '0;
      pc_sent  <= 1'b0;
      mul_pend <= '0;
      mul_lane <= '0;
      mul_cnt  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      for (int i = 0; i < LANES; i++) mul_res[i] <= '0;
    end else if (flush) begin
      h_valid  <= '0;
      pc_sent  <= 1'b0;
      mul_pend <= '0;
    end else if (accept) begin
      h_valid  <= in_valid;
      h_exsign <= exsign;
      h_pc     <= pc;
      h_rs     <= rs_val;
      h_rt     <= rt_val;
      h_ba     <= byp_a;
      h_bb     <= byp_b;
      h_imm    <= imm;
      h_asel   <= srca_sel;
      h_bsel   <= srcb_sel;
      h_pcsrc  <= pcsrc;
      h_op     <= alu_op;
      pc_sent  <= 1'b0;
      mul_lane <= lowest(in_mul);
      mul_pend <= in_mul & (in_mul - LANES'(1));
      mcand    <= in_a[lowest(in_mul)];
      mplier   <= in_b[lowest(in_mul)];
      acc      <= '0;
      mul_cnt  <= '0;
    end else begin
      if (state == S_DONE) begin
        if (set_pc)    pc_sent <= 1'b1;
        if (out_ready) h_valid <= '0;
      end
      if (state == S_MUL) begin
        acc     <= acc_nx;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + CW'(1);
        if (mul_last) begin
          mul_res[mul_lane] <= acc_nx;
          mul_cnt <= '0;
          acc     <= '0;
          if (mul_pend != '0) begin
            mul_lane <= lowest(mul_pend);
            mul_pend <= mul_pend & (mul_pend - LANES'(1));
            mcand    <= op_a[lowest(mul_pend)];
            mplier   <= op_b[lowest(mul_pend)];
          end
        end
      end
    end
  end

endmodule
